// File: rtl/csi_packet_sequencer.sv
// csi_packet_sequencer: CSI-2 byte framer that gathers headers, checks them through an external ECC block and forwards payload.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   byte_in/valid/sop received byte stream; sop marks header byte 0
//   ecc_ph            registered raw header to the combinational ecc_block
//   ecc_ph_corr/ecc_* corrected header and status back from ecc_block
//   hdr_valid + fields decoded header (vc, data type, word count, short flag)
//   payload_*         long-packet payload bytes with last marker
//   pkt_done/abort    packet completed / cut by a new sop
//   hdr_err           uncorrectable header, packet dropped
//   corr_count/err_count saturating header statistics
module csi_packet_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             sop,
  output logic [31:0]      ecc_ph,
  input  logic [23:0]      ecc_ph_corr,
  input  logic             ecc_no_error,
  input  logic             ecc_corrected,
  input  logic             ecc_error,
  output logic             hdr_valid,
  output logic [1:0]       virtual_channel,
  output logic [5:0]       data_type,
  output logic [15:0]      word_count,
  output logic             is_short,
  output logic [7:0]       payload_data,
  output logic             payload_valid,
  output logic             payload_last,
  output logic             pkt_done,
  output logic             pkt_abort,
  output logic             hdr_err,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [2:0] IDLE = 3'd0, HEADER = 3'd1, CHECK = 3'd2, PAYLOAD = 3'd3, CRC = 3'd4, DROP = 3'd5;
  logic [2:0]  state;
  logic [1:0]  hdr_idx;
  logic [23:0] hdr_buf;
  logic [15:0] remaining;
  logic [15:0] corr_wc;
  logic        crc_cnt, start, corr_short, check_last, unused_ok;
  assign start      = byte_valid & sop;
  assign corr_wc    = ecc_ph_corr[23:8];
  assign corr_short = ecc_ph_corr[5:4] == 2'b00;
  assign check_last = byte_valid & (corr_wc == 16'd1);
  // Clean vs. corrected is fully described by ecc_error/ecc_corrected.
  assign unused_ok  = ecc_no_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      hdr_idx         <= '0;
      hdr_buf         <= '0;
      remaining       <= '0;
      crc_cnt         <= 1'b0;
      ecc_ph          <= '0;
      hdr_valid       <= 1'b0;
      virtual_channel <= '0;
      data_type       <= '0;
      word_count      <= '0;
      is_short        <= 1'b0;
      payload_data    <= '0;
      payload_valid   <= 1'b0;
      payload_last    <= 1'b0;
      pkt_done        <= 1'b0;
      pkt_abort       <= 1'b0;
      hdr_err         <= 1'b0;
      corr_count      <= '0;
      err_count       <= '0;
    end else begin
      hdr_valid     <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_abort     <= 1'b0;
      hdr_err       <= 1'b0;
      // The header verdict is reported even if a new sop cuts the packet in CHECK.
      if (state == CHECK) begin
        if (ecc_error) begin
          hdr_err   <= 1'b1;
          err_count <= err_count + CNT_W'(~&err_count);
        end else begin
          hdr_valid       <= 1'b1;
          virtual_channel <= ecc_ph_corr[7:6];
          data_type       <= ecc_ph_corr[5:0];
          word_count      <= corr_wc;
          is_short        <= corr_short;
          pkt_done        <= corr_short & ~start;
          if (ecc_corrected) corr_count <= corr_count + CNT_W'(~&corr_count);
        end
      end
      if (start) begin
        state        <= HEADER;
        hdr_buf[7:0] <= byte_in;
        hdr_idx      <= 2'd1;
        pkt_abort    <= (state != IDLE) && (state != DROP);
      end else if (byte_valid || state == CHECK) begin
        case (state)
          HEADER: begin
            hdr_idx         <= hdr_idx + 2'd1;
            hdr_buf[15:8]   <= (hdr_idx == 2'd1) ? byte_in : hdr_buf[15:8];
            hdr_buf[23:16]  <= (hdr_idx == 2'd2) ? byte_in : hdr_buf[23:16];
            if (hdr_idx == 2'd3) begin
              ecc_ph <= {byte_in, hdr_buf};
              state  <= CHECK;
            end
          end
          // A byte arriving during CHECK is already payload byte 1 or CRC byte 1.
          CHECK: begin
            crc_cnt   <= byte_valid & (corr_wc == 16'd0);
            remaining <= corr_wc - 16'(byte_valid);
            if (ecc_error) state <= DROP;
            else if (corr_short) state <= IDLE;
            else if (corr_wc == 16'd0) state <= CRC;
            else begin
              if (byte_valid) payload_data <= byte_in;
              payload_valid <= byte_valid;
              payload_last  <= check_last;
              state         <= check_last ? CRC : PAYLOAD;
            end
          end
          PAYLOAD: begin
            payload_data  <= byte_in;
            payload_valid <= 1'b1;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              payload_last <= 1'b1;
              crc_cnt      <= 1'b0;
              state        <= CRC;
            end
          end
          CRC: begin
            crc_cnt <= 1'b1;
            if (crc_cnt) begin
              pkt_done <= 1'b1;
              state    <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csi_packet_sequencer.sv
// tb_csi_packet_sequencer: randomized scoreboard bench for csi_packet_sequencer with a packet-level reference model.
module tb_csi_packet_sequencer;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0, sop = 1'b0;
  logic [31:0] ecc_ph;
  logic [23:0] ecc_ph_corr;
  logic ecc_no_error, ecc_corrected, ecc_error;
  logic hdr_valid, is_short, payload_valid, payload_last, pkt_done, pkt_abort, hdr_err;
  logic [1:0] virtual_channel;
  logic [5:0] data_type;
  logic [15:0] word_count;
  logic [7:0] payload_data;
  logic [CW-1:0] corr_count, err_count;

  typedef struct {int t; logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic sh; int corr; int err; logic [31:0] ph;} hdr_t;
  typedef struct {int t; logic [7:0] d; logic l;} pl_t;
  hdr_t hq[$], eq[$];
  pl_t pq[$];
  int dq[$], aq[$];
  logic [7:0] fixed_pl[$];
  hdr_t mh;
  pl_t mp;
  int cyc = 0, checks = 0, fails = 0;
  int corr_m = 0, err_m = 0, mode = 0, flip_bit = 9;
  bit in_pkt = 0;
  logic [23:0] true_hdr = '0;

  csi_packet_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .sop(sop),
    .ecc_ph(ecc_ph), .ecc_ph_corr(ecc_ph_corr), .ecc_no_error(ecc_no_error),
    .ecc_corrected(ecc_corrected), .ecc_error(ecc_error), .hdr_valid(hdr_valid),
    .virtual_channel(virtual_channel), .data_type(data_type), .word_count(word_count),
    .is_short(is_short), .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_last(payload_last), .pkt_done(pkt_done), .pkt_abort(pkt_abort),
    .hdr_err(hdr_err), .corr_count(corr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ECC stub: clean passes the header through, corrected returns the true header.
  assign ecc_ph_corr   = (mode == 1) ? true_hdr : ecc_ph[23:0];
  assign ecc_no_error  = mode == 0;
  assign ecc_corrected = mode == 1;
  assign ecc_error     = mode == 2;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return v < CMAX ? v + 1 : v;
  endfunction

  always @(negedge clk) if (!reset) begin
    if (hdr_valid) begin
      if (hq.size() == 0) chk("hdr_valid_unexpected", 1, 0);
      else begin
        mh = hq.pop_front();
        chk("hdr_time", cyc, mh.t);
        chk("vc", virtual_channel, mh.vc);
        chk("dt", data_type, mh.dt);
        chk("wc", word_count, mh.wc);
        chk("is_short", is_short, mh.sh);
        chk("corr_count", corr_count, mh.corr);
        chk("err_count", err_count, mh.err);
        chk("ecc_ph", ecc_ph, mh.ph);
      end
    end
    if (hdr_err) begin
      if (eq.size() == 0) chk("hdr_err_unexpected", 1, 0);
      else begin
        mh = eq.pop_front();
        chk("hdr_err_time", cyc, mh.t);
        chk("err_count_e", err_count, mh.err);
        chk("corr_count_e", corr_count, mh.corr);
        chk("ecc_ph_e", ecc_ph, mh.ph);
      end
    end
    if (payload_valid) begin
      if (pq.size() == 0) chk("payload_unexpected", 1, 0);
      else begin
        mp = pq.pop_front();
        chk("pl_time", cyc, mp.t);
        chk("pl_data", payload_data, mp.d);
        chk("pl_last", payload_last, mp.l);
      end
    end
    if (payload_last) chk("last_without_valid", payload_valid, 1);
    if (pkt_done) begin
      if (dq.size() == 0) chk("pkt_done_unexpected", 1, 0);
      else chk("done_time", cyc, dq.pop_front());
    end
    if (pkt_abort) begin
      if (aq.size() == 0) chk("pkt_abort_unexpected", 1, 0);
      else chk("abort_time", cyc, aq.pop_front());
    end
  end

  task automatic drive(input logic [7:0] b, input logic s, output int t);
    @(negedge clk);
    byte_in = b; sop = s; byte_valid = 1'b1; t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0; sop = 1'b0; byte_in = 8'($urandom);
    end
  endtask

  task automatic junk(input int n);
    int t;
    repeat (n) drive(8'($urandom), 1'b0, t);
    idle(1);
  endtask

  // Packet-level model: expectations are derived from each byte's role in the packet.
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input int md, input int cut, input bit gaps);
    logic [23:0] h;
    logic [31:0] ph;
    logic [7:0] b;
    bit sh, lng;
    int n, t;
    h = {wc, vc, dt};
    sh = dt <= 6'h0F;
    lng = !sh && md != 2;
    n = lng ? 6 + int'(wc) : 4;
    ph = {8'($urandom), h};
    if (md == 1) ph[flip_bit] = ~ph[flip_bit];
    for (int i = 0; i < n && i != cut; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      if (i < 4) b = ph[8*i +: 8];
      else if (i < 4 + int'(wc) && fixed_pl.size() > 0) b = fixed_pl.pop_front();
      else b = 8'($urandom);
      if (i == 3) begin mode = md; true_hdr = h; end
      drive(b, i == 0, t);
      if (i == 0) begin
        if (in_pkt) aq.push_back(t + 1);
        in_pkt = 1;
      end
      if (i == 3) begin
        if (md == 2) begin
          err_m = sat(err_m);
          eq.push_back('{t + 2, vc, dt, wc, sh, corr_m, err_m, ph});
          in_pkt = 0;
        end else begin
          if (md == 1) corr_m = sat(corr_m);
          hq.push_back('{t + 2, vc, dt, wc, sh, corr_m, err_m, ph});
          if (sh) begin dq.push_back(t + 2); in_pkt = 0; end
        end
      end
      if (lng && i >= 4 && i < 4 + int'(wc)) pq.push_back('{t + 1, b, i == 3 + int'(wc)});
      if (lng && i == n - 1) begin dq.push_back(t + 1); in_pkt = 0; end
    end
    idle(1);
  endtask

  initial begin
    idle(3);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_payload_valid", payload_valid, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_ecc_ph", ecc_ph, 0);
    chk("rst_corr_count", corr_count, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk) reset = 1'b0;
    // Short packet, clean header.
    send_pkt(2'd0, 6'h00, 16'h1234, 0, -1, 0);
    // Long packet with fixed payload.
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(2'd0, 6'h2A, 16'd4, 0, -1, 0);
    // Corrected header: WC 0006 on the wire, 0004 after correction.
    flip_bit = 9;
    send_pkt(2'd0, 6'h2A, 16'd4, 1, -1, 0);
    // Uncorrectable header, trailing bytes dropped, then a normal packet.
    send_pkt(2'd1, 6'h2B, 16'd3, 2, -1, 0);
    junk(10);
    send_pkt(2'd2, 6'h2C, 16'd2, 0, -1, 0);
    // Abort after payload byte 2 of a WC=8 packet, then with gaps.
    send_pkt(2'd0, 6'h2A, 16'd8, 0, 6, 0);
    send_pkt(2'd3, 6'h12, 16'd5, 0, -1, 0);
    send_pkt(2'd0, 6'h2A, 16'd8, 0, 6, 1);
    send_pkt(2'd3, 6'h12, 16'd5, 0, -1, 1);
    // Long packet with WC=0 and WC=1.
    send_pkt(2'd1, 6'h30, 16'd0, 0, -1, 0);
    send_pkt(2'd1, 6'h31, 16'd1, 0, -1, 0);
    // Drive err_count into saturation.
    repeat (CMAX + 2) send_pkt(2'($urandom), 6'($urandom), 16'($urandom_range(0, 6)), 2, -1, 0);
    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      logic [5:0] dt;
      logic [15:0] wc;
      int md, cut, n;
      dt = 6'($urandom);
      md = $urandom_range(0, 9);
      md = md < 7 ? 0 : (md < 9 ? 1 : 2);
      wc = (dt <= 6'h0F) ? 16'($urandom) : 16'($urandom_range(0, 12));
      n = (dt > 6'h0F && md != 2) ? 6 + int'(wc) : 4;
      flip_bit = $urandom_range(0, 23);
      cut = -1;
      if ($urandom_range(0, 3) == 0)
        cut = (n > 5 && $urandom_range(0, 1) == 1) ? $urandom_range(5, n - 1) : $urandom_range(1, 3);
      send_pkt(2'($urandom), dt, wc, md, cut, $urandom_range(0, 1) == 1);
      if (!in_pkt && $urandom_range(0, 4) == 0) junk($urandom_range(1, 4));
    end
    send_pkt(2'd0, 6'h2A, 16'd3, 0, -1, 0);
    // Reset in the middle of a payload.
    send_pkt(2'd0, 6'h2A, 16'd8, 0, 6, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_payload_valid", payload_valid, 0);
    chk("mid_rst_payload_data", payload_data, 0);
    chk("mid_rst_pkt_abort", pkt_abort, 0);
    chk("mid_rst_hdr_valid", hdr_valid, 0);
    chk("mid_rst_word_count", word_count, 0);
    chk("mid_rst_ecc_ph", ecc_ph, 0);
    chk("mid_rst_corr_count", corr_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    reset = 1'b0;
    corr_m = 0; err_m = 0; in_pkt = 0;
    send_pkt(2'd2, 6'h2E, 16'd3, 1, -1, 1);
    idle(10);
    chk("hdr_queue_drained", hq.size(), 0);
    chk("err_queue_drained", eq.size(), 0);
    chk("payload_queue_drained", pq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    chk("abort_queue_drained", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
